// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: bit-period config, byte capture with parity check,
// show-ahead FIFO, and overrun/timeout/threshold interrupt generation.
`timescale 1ns/1ps
module uart_rx_ctrl #(
    parameter int unsigned       DEPTH_LOG2     = 3,
    parameter int unsigned       TO_W           = 16,
    parameter logic [TO_W-1:0]   TIMEOUT_CYCLES = TO_W'(4000),
    parameter logic [11:0]       WORK_FR_RST    = 12'd434
) (
    input  logic                  PCLK,
    input  logic                  RESET,
    input  logic                  CFG_WE,
    input  logic [11:0]           CFG_WORK_FR,
    input  logic                  CFG_PARITY_EN,
    input  logic                  CFG_PARITY_ODD,
    input  logic [DEPTH_LOG2:0]   CFG_THRESH,
    output logic [11:0]           WORK_FR_O,
    input  logic                  RX_READY,
    input  logic [7:0]            RX_DATA,
    input  logic                  RX_PARITY,
    input  logic                  RD_EN,
    output logic [7:0]            RD_DATA,
    output logic                  RD_PERR,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic [DEPTH_LOG2:0]   LEVEL,
    input  logic                  CLR_ERR,
    output logic                  OVERRUN,
    output logic                  TIMEOUT,
    output logic                  IRQ
);

    localparam int unsigned    DEPTH    = 2 ** DEPTH_LOG2;
    localparam int unsigned    PW       = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]  MSB_ONLY = PW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_PUSH} state_t;

    state_t            state;
    logic              rx_ready_q;
    logic              rx_pend;
    logic [7:0]        hold_data;
    logic              hold_par;
    logic              hold_perr;

    logic [8:0]        mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr_nxt;
    logic [PW-1:0]     rd_ptr_nxt;
    logic [PW-1:0]     level_nxt;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_cnt_nxt;

    logic              capture;
    logic              push_req;
    logic              push;
    logic              pop;

    // A READY edge seen while busy is remembered and honoured in S_IDLE if the level is still high.
    always_comb begin
        capture    = RX_READY & (~rx_ready_q | rx_pend);
        push_req   = (state == S_PUSH);
        push       = push_req & ~FULL;
        pop        = RD_EN & ~EMPTY;
        wr_ptr_nxt = wr_ptr + PW'(push);
        rd_ptr_nxt = rd_ptr + PW'(pop);
        level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
        to_cnt_nxt = to_cnt;
        if (push || pop || EMPTY) begin
            to_cnt_nxt = '0;
        end else if (to_cnt != TIMEOUT_CYCLES) begin
            to_cnt_nxt = to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            rx_ready_q <= 1'b0;
            rx_pend    <= 1'b0;
            hold_data  <= '0;
            hold_par   <= 1'b0;
            hold_perr  <= 1'b0;
        end else begin
            rx_ready_q <= RX_READY;
            case (state)
                S_IDLE: begin
                    rx_pend <= 1'b0;
                    if (capture) begin
                        hold_data <= RX_DATA;
                        hold_par  <= RX_PARITY;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    hold_perr <= CFG_PARITY_EN & (^hold_data ^ hold_par ^ CFG_PARITY_ODD);
                    if (RX_READY && !rx_ready_q) rx_pend <= 1'b1;
                    state <= S_PUSH;
                end
                S_PUSH: begin
                    if (RX_READY && !rx_ready_q) rx_pend <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {hold_perr, hold_data};
    end

    // Status and head byte are registered from next-state pointers; a write into the head slot bypasses memory.
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            RD_DATA   <= '0;
            RD_PERR   <= 1'b0;
            EMPTY     <= 1'b1;
            FULL      <= 1'b0;
            LEVEL     <= '0;
            OVERRUN   <= 1'b0;
            TIMEOUT   <= 1'b0;
            IRQ       <= 1'b0;
            to_cnt    <= '0;
            WORK_FR_O <= WORK_FR_RST;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            LEVEL   <= level_nxt;
            EMPTY   <= (wr_ptr_nxt == rd_ptr_nxt);
            FULL    <= ((wr_ptr_nxt ^ rd_ptr_nxt) == MSB_ONLY);
            if (wr_ptr_nxt == rd_ptr_nxt) begin
                {RD_PERR, RD_DATA} <= '0;
            end else if (push && (wr_ptr == rd_ptr_nxt)) begin
                {RD_PERR, RD_DATA} <= {hold_perr, hold_data};
            end else begin
                {RD_PERR, RD_DATA} <= mem[rd_ptr_nxt[DEPTH_LOG2-1:0]];
            end
            if (push_req && FULL) begin
                OVERRUN <= 1'b1;
            end else if (CLR_ERR) begin
                OVERRUN <= 1'b0;
            end
            to_cnt  <= to_cnt_nxt;
            TIMEOUT <= (to_cnt_nxt == TIMEOUT_CYCLES);
            IRQ     <= ((CFG_THRESH != '0) && (LEVEL >= CFG_THRESH)) | TIMEOUT | OVERRUN;
            if (CFG_WE) WORK_FR_O <= CFG_WORK_FR;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (timeout shortened to 16 cycles).
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    logic        PCLK = 1'b0;
    logic        RESET;
    logic        CFG_WE;
    logic [11:0] CFG_WORK_FR;
    logic        CFG_PARITY_EN;
    logic        CFG_PARITY_ODD;
    logic [3:0]  CFG_THRESH;
    logic [11:0] WORK_FR_O;
    logic        RX_READY;
    logic [7:0]  RX_DATA;
    logic        RX_PARITY;
    logic        RD_EN;
    logic [7:0]  RD_DATA;
    logic        RD_PERR;
    logic        EMPTY;
    logic        FULL;
    logic [3:0]  LEVEL;
    logic        CLR_ERR;
    logic        OVERRUN;
    logic        TIMEOUT;
    logic        IRQ;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_ctrl #(
        .DEPTH_LOG2     (3),
        .TO_W           (16),
        .TIMEOUT_CYCLES (16'd16),
        .WORK_FR_RST    (12'd434)
    ) dut (
        .PCLK           (PCLK),
        .RESET          (RESET),
        .CFG_WE         (CFG_WE),
        .CFG_WORK_FR    (CFG_WORK_FR),
        .CFG_PARITY_EN  (CFG_PARITY_EN),
        .CFG_PARITY_ODD (CFG_PARITY_ODD),
        .CFG_THRESH     (CFG_THRESH),
        .WORK_FR_O      (WORK_FR_O),
        .RX_READY       (RX_READY),
        .RX_DATA        (RX_DATA),
        .RX_PARITY      (RX_PARITY),
        .RD_EN          (RD_EN),
        .RD_DATA        (RD_DATA),
        .RD_PERR        (RD_PERR),
        .EMPTY          (EMPTY),
        .FULL           (FULL),
        .LEVEL          (LEVEL),
        .CLR_ERR        (CLR_ERR),
        .OVERRUN        (OVERRUN),
        .TIMEOUT        (TIMEOUT),
        .IRQ            (IRQ)
    );

    always #5 PCLK = ~PCLK;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge PCLK);
    endtask

    task automatic pulse_ready(input logic [7:0] d, input logic p);
        RX_DATA   = d;
        RX_PARITY = p;
        RX_READY  = 1'b1;
        @(negedge PCLK);
        RX_READY  = 1'b0;
    endtask

    // Leaves the bench at the first sample point where the byte is visible.
    task automatic recv(input logic [7:0] d, input logic p);
        pulse_ready(d, p);
        idle(2);
    endtask

    task automatic pop1();
        RD_EN = 1'b1;
        @(negedge PCLK);
        RD_EN = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        idle(2);
        RESET = 1'b0;
        n_cmp++;
        if (WORK_FR_O !== 12'd434) begin
            n_bad++; $display("FAIL reset_work_fr: got %0d want 434", WORK_FR_O);
        end
        n_cmp++;
        if ({RD_PERR, RD_DATA} !== 9'h000) begin
            n_bad++; $display("FAIL reset_rd: got %h want 000", {RD_PERR, RD_DATA});
        end
        n_cmp++;
        if ({EMPTY, FULL, LEVEL} !== 6'b10_0000) begin
            n_bad++; $display("FAIL reset_status: got %b want 100000", {EMPTY, FULL, LEVEL});
        end
        n_cmp++;
        if ({OVERRUN, TIMEOUT, IRQ} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000", {OVERRUN, TIMEOUT, IRQ});
        end
    endtask

    task automatic test_basic();
        CFG_PARITY_EN  = 1'b1;
        CFG_PARITY_ODD = 1'b0;
        pulse_ready(8'hA5, 1'b0);
        idle(1);
        n_cmp++;
        if (EMPTY !== 1'b1) begin
            n_bad++; $display("FAIL basic_latency: EMPTY got %b want 1 at N+2", EMPTY);
        end
        idle(1);
        n_cmp++;
        if ({EMPTY, LEVEL, RD_PERR, RD_DATA} !== {1'b0, 4'd1, 1'b0, 8'hA5}) begin
            n_bad++; $display("FAIL basic_rx: got E=%b L=%0d P=%b D=%h want E=0 L=1 P=0 D=a5",
                              EMPTY, LEVEL, RD_PERR, RD_DATA);
        end
        pop1();
        n_cmp++;
        if ({EMPTY, LEVEL} !== {1'b1, 4'd0}) begin
            n_bad++; $display("FAIL basic_pop: got E=%b L=%0d want E=1 L=0", EMPTY, LEVEL);
        end
    endtask

    task automatic test_parity();
        logic [2:0] en_v  = 3'b011;
        logic [2:0] par_v = 3'b010;
        logic [2:0] exp_v = 3'b001;
        CFG_PARITY_ODD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            CFG_PARITY_EN = en_v[i];
            recv(8'h03, par_v[i]);
            n_cmp++;
            if ({RD_PERR, RD_DATA} !== {exp_v[i], 8'h03}) begin
                n_bad++; $display("FAIL parity_%0d: got P=%b D=%h want P=%b D=03",
                                  i, RD_PERR, RD_DATA, exp_v[i]);
            end
            pop1();
        end
        CFG_PARITY_EN = 1'b0;
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 8; i++) recv(8'(i), 1'b0);
        n_cmp++;
        if ({FULL, LEVEL} !== {1'b1, 4'd8}) begin
            n_bad++; $display("FAIL ovr_full: got F=%b L=%0d want F=1 L=8", FULL, LEVEL);
        end
        recv(8'hFF, 1'b0);
        n_cmp++;
        if ({OVERRUN, IRQ, LEVEL, RD_DATA} !== {1'b1, 1'b0, 4'd8, 8'h00}) begin
            n_bad++; $display("FAIL ovr_set: got O=%b I=%b L=%0d D=%h want O=1 I=0 L=8 D=00",
                              OVERRUN, IRQ, LEVEL, RD_DATA);
        end
        idle(1);
        n_cmp++;
        if (IRQ !== 1'b1) begin
            n_bad++; $display("FAIL ovr_irq: got %b want 1", IRQ);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (RD_DATA !== 8'(i)) begin
                n_bad++; $display("FAIL ovr_drain_%0d: got %h want %h", i, RD_DATA, 8'(i));
            end
            pop1();
        end
        n_cmp++;
        if ({EMPTY, OVERRUN} !== 2'b11) begin
            n_bad++; $display("FAIL ovr_sticky: got E=%b O=%b want E=1 O=1", EMPTY, OVERRUN);
        end
        CLR_ERR = 1'b1;
        idle(1);
        CLR_ERR = 1'b0;
        n_cmp++;
        if (OVERRUN !== 1'b0) begin
            n_bad++; $display("FAIL ovr_clear: got %b want 0", OVERRUN);
        end
        idle(1);
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_bad++; $display("FAIL ovr_irq_clear: got %b want 0", IRQ);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] nb;
        for (int i = 0; i < 3; i++) begin
            recv(8'h10 + 8'(i), 1'b0);
            q.push_back(8'h10 + 8'(i));
        end
        for (int k = 0; k < 20; k++) begin
            nb = 8'h40 + 8'(k);
            pulse_ready(nb, 1'b0);
            RD_EN = 1'b1;
            idle(1);
            RD_EN = 1'b0;
            idle(1);
            void'(q.pop_front());
            q.push_back(nb);
            n_cmp++;
            if ({LEVEL, RD_DATA} !== {4'd3, q[0]}) begin
                n_bad++; $display("FAIL b2b_%0d: got L=%0d D=%h want L=3 D=%h", k, LEVEL, RD_DATA, q[0]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (RD_DATA !== q[i]) begin
                n_bad++; $display("FAIL b2b_drain_%0d: got %h want %h", i, RD_DATA, q[i]);
            end
            pop1();
        end
        n_cmp++;
        if (EMPTY !== 1'b1) begin
            n_bad++; $display("FAIL b2b_empty: got %b want 1", EMPTY);
        end
    endtask

    task automatic test_thresh_timeout();
        CFG_THRESH = 4'd4;
        for (int i = 0; i < 4; i++) recv(8'h20 + 8'(i), 1'b0);
        n_cmp++;
        if ({LEVEL, IRQ} !== {4'd4, 1'b0}) begin
            n_bad++; $display("FAIL thr_pre: got L=%0d I=%b want L=4 I=0", LEVEL, IRQ);
        end
        idle(1);
        n_cmp++;
        if (IRQ !== 1'b1) begin
            n_bad++; $display("FAIL thr_irq: got %b want 1", IRQ);
        end
        pop1();
        idle(1);
        n_cmp++;
        if ({LEVEL, IRQ} !== {4'd3, 1'b0}) begin
            n_bad++; $display("FAIL thr_drop: got L=%0d I=%b want L=3 I=0", LEVEL, IRQ);
        end
        for (int i = 0; i < 3; i++) pop1();
        CFG_THRESH = 4'd0;
        idle(1);

        recv(8'h77, 1'b0);
        idle(15);
        n_cmp++;
        if (TIMEOUT !== 1'b0) begin
            n_bad++; $display("FAIL to_early: got %b want 0 after 15 cycles", TIMEOUT);
        end
        idle(1);
        n_cmp++;
        if ({TIMEOUT, IRQ} !== 2'b10) begin
            n_bad++; $display("FAIL to_rise: got T=%b I=%b want T=1 I=0", TIMEOUT, IRQ);
        end
        idle(4);
        n_cmp++;
        if ({TIMEOUT, IRQ} !== 2'b11) begin
            n_bad++; $display("FAIL to_hold: got T=%b I=%b want T=1 I=1", TIMEOUT, IRQ);
        end
        pop1();
        n_cmp++;
        if (TIMEOUT !== 1'b0) begin
            n_bad++; $display("FAIL to_pop: got %b want 0", TIMEOUT);
        end
        idle(1);
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_bad++; $display("FAIL to_irq_clear: got %b want 0", IRQ);
        end
    endtask

    task automatic test_cfg_reset();
        CFG_WORK_FR = 12'd100;
        CFG_WE      = 1'b1;
        idle(1);
        CFG_WE      = 1'b0;
        n_cmp++;
        if (WORK_FR_O !== 12'd100) begin
            n_bad++; $display("FAIL cfg_we: got %0d want 100", WORK_FR_O);
        end
        recv(8'h55, 1'b0);
        pulse_ready(8'h66, 1'b0);
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
        n_cmp++;
        if ({WORK_FR_O, RD_PERR, RD_DATA, EMPTY, FULL, LEVEL, OVERRUN, TIMEOUT, IRQ}
            !== {12'd434, 9'h000, 1'b1, 1'b0, 4'd0, 3'b000}) begin
            n_bad++; $display("FAIL rst_mid: got W=%0d D=%h E=%b F=%b L=%0d O=%b T=%b I=%b",
                              WORK_FR_O, RD_DATA, EMPTY, FULL, LEVEL, OVERRUN, TIMEOUT, IRQ);
        end
        idle(4);
        n_cmp++;
        if ({EMPTY, LEVEL, RD_DATA} !== {1'b1, 4'd0, 8'h00}) begin
            n_bad++; $display("FAIL rst_discard: got E=%b L=%0d D=%h want E=1 L=0 D=00",
                              EMPTY, LEVEL, RD_DATA);
        end
    endtask

    initial begin
        RESET = 1'b1; CFG_WE = 1'b0; CFG_WORK_FR = '0;
        CFG_PARITY_EN = 1'b0; CFG_PARITY_ODD = 1'b0; CFG_THRESH = '0;
        RX_READY = 1'b0; RX_DATA = '0; RX_PARITY = 1'b0;
        RD_EN = 1'b0; CLR_ERR = 1'b0;
        @(negedge PCLK);
        test_reset();
        test_basic();
        test_parity();
        test_overrun();
        test_back_to_back();
        test_thresh_timeout();
        test_cfg_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded 200000 ns");
        $fatal(1);
    end

endmodule
